fifo_cov_monitor: RTL



---
 rtl/fifo_cov_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_cov_monitor.sv
// Passive FIFO monitor: shadow occupancy, handshake protocol checks and per-occupancy coverage.
// Define MON_DATA_CHECK_EN to add a shadow data queue that checks dequeue ordering (error code 5).
module fifo_cov_monitor #(
   parameter int WIDTH_P = 8,
   parameter int CAP_P   = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     enq_valid_i,
   input  logic                     enq_ready_i,
   input  logic [WIDTH_P-1:0]       enq_data_i,
   input  logic                     deq_valid_i,
   input  logic                     deq_yumi_i,
   input  logic [WIDTH_P-1:0]       deq_data_i,
   output logic [$clog2(CAP_P):0]   occ_o,
   output logic [3*(CAP_P+1)-1:0]   covers_o,
   output logic                     all_covered_o,
   output logic                     err_o,
   output logic [2:0]               err_code_o
);

   localparam int OCC_W = $clog2(CAP_P) + 1;
   localparam int COV_W = CAP_P + 1;
   localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(CAP_P);
   localparam logic [OCC_W-1:0] OCC_EMPTY = '0;

   // Coverage bits that legal traffic can actually reach at each occupancy.
   localparam logic [COV_W-1:0] ENQ_MASK  = {1'b0, {CAP_P{1'b1}}};
   localparam logic [COV_W-1:0] DEQ_MASK  = {{CAP_P{1'b1}}, 1'b0};
   localparam logic [COV_W-1:0] BOTH_MASK = {1'b0, {(CAP_P-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      ERR_NONE           = 3'd0,
      ERR_READY_MISMATCH = 3'd1,
      ERR_VALID_MISMATCH = 3'd2,
      ERR_OVERFLOW       = 3'd3,
      ERR_UNDERFLOW      = 3'd4,
      ERR_DATA_MISMATCH  = 3'd5
   } err_code_t;

   logic             enq_fire;
   logic             deq_fire;
   logic             enq_only;
   logic             deq_only;
   logic             both_fire;
   logic             is_full;
   logic             is_empty;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_next;
   logic [COV_W-1:0] occ_onehot;
   logic [COV_W-1:0] enqs_q;
   logic [COV_W-1:0] deqs_q;
   logic [COV_W-1:0] boths_q;
   logic             ready_mismatch;
   logic             valid_mismatch;
   logic             overflow;
   logic             underflow;
   logic             data_mismatch;
   err_code_t        first_code;
   logic             err_q;
   err_code_t        err_code_q;

   assign enq_fire  = enq_valid_i & enq_ready_i;
   assign deq_fire  = deq_yumi_i;
   assign enq_only  = enq_fire & ~deq_fire;
   assign deq_only  = deq_fire & ~enq_fire;
   assign both_fire = enq_fire & deq_fire;

   assign is_full    = (occ_q == OCC_FULL);
   assign is_empty   = (occ_q == OCC_EMPTY);
   assign occ_onehot = {{(COV_W-1){1'b0}}, 1'b1} << occ_q;

   // Saturating occupancy; simultaneous enq and deq leave it unchanged.
   always_comb begin
      occ_next = occ_q;
      if (enq_only && !is_full) begin
         occ_next = occ_q + 1'b1;
      end else if (deq_only && !is_empty) begin
         occ_next = occ_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         occ_q   <= '0;
         enqs_q  <= '0;
         deqs_q  <= '0;
         boths_q <= '0;
      end else begin
         occ_q <= occ_next;
         if (enq_only) begin
            enqs_q <= enqs_q | occ_onehot;
         end
         if (deq_only) begin
            deqs_q <= deqs_q | occ_onehot;
         end
         if (both_fire) begin
            boths_q <= boths_q | occ_onehot;
         end
      end
   end

   assign ready_mismatch = enq_ready_i != !is_full;
   assign valid_mismatch = deq_valid_i != !is_empty;
   assign overflow       = enq_fire & ~deq_fire & is_full;
   assign underflow      = deq_yumi_i & is_empty;

`ifdef MON_DATA_CHECK_EN
   localparam int PTR_W = $clog2(CAP_P);

   logic [WIDTH_P-1:0] shadow_mem [CAP_P];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               pop;

   // The head is read before the edge, so a push into the same slot when full cannot corrupt it.
   assign pop           = deq_fire & ~is_empty;
   assign data_mismatch = pop & (deq_data_i != shadow_mem[rd_ptr]);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (enq_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         shadow_mem[wr_ptr] <= enq_data_i;
      end
   end
`else
   logic unused_data;

   assign unused_data   = ^{enq_data_i, deq_data_i};
   assign data_mismatch = 1'b0;
`endif

   // Lowest-numbered firing check wins when several fire together.
   always_comb begin
      first_code = ERR_NONE;
      if (ready_mismatch) begin
         first_code = ERR_READY_MISMATCH;
      end else if (valid_mismatch) begin
         first_code = ERR_VALID_MISMATCH;
      end else if (overflow) begin
         first_code = ERR_OVERFLOW;
      end else if (underflow) begin
         first_code = ERR_UNDERFLOW;
      end else if (data_mismatch) begin
         first_code = ERR_DATA_MISMATCH;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else if (!err_q && (first_code != ERR_NONE)) begin
         err_q      <= 1'b1;
         err_code_q <= first_code;
      end
   end

   assign occ_o         = occ_q;
   assign covers_o      = {enqs_q, deqs_q, boths_q};
   assign all_covered_o = ((enqs_q & ENQ_MASK) == ENQ_MASK)
                        & ((deqs_q & DEQ_MASK) == DEQ_MASK)
                        & ((boths_q & BOTH_MASK) == BOTH_MASK);
   assign err_o         = err_q;
   assign err_code_o    = err_code_q;

endmodule
